// File: rtl/alu_decode_unit.sv
// alu_decode_unit: one-cycle instruction group/field decoder and 8/16-bit ALU.
// Every output is registered; result registers load only on in_valid and are
// cleared asynchronously while reset is low.
module alu_decode_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [15:0] instr_hi,
    input  logic [3:0]  alu_oper,
    input  logic [7:0]  alu_a_hi,
    input  logic [7:0]  alu_a_lo,
    input  logic [7:0]  alu_b,
    input  logic [3:0]  flags_in,
    output logic [2:0]  group_out,
    output logic        instr_is_32_bit,
    output logic [2:0]  ig1_opcode,
    output logic [3:0]  ig1_ra_index,
    output logic [7:0]  ig1_imm8,
    output logic        ig1_ra_is_pair,
    output logic [7:0]  alu_out_hi,
    output logic [7:0]  alu_out_lo,
    output logic [3:0]  flags_out,
    output logic        out_valid
);

    localparam int FLAG_Z = 0;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 2;
    localparam int FLAG_N = 3;

    logic [2:0]  group_nxt;
    logic        pair_nxt;
    logic        is_sub;
    logic [7:0]  b_eff;
    logic        cin_eff;
    logic [8:0]  sum9;
    logic        v_arith;
    logic [15:0] b_sext;
    logic [15:0] pair_sum;
    logic [15:0] pair_diff;
    logic [7:0]  lo_nxt;
    logic [7:0]  hi_nxt;
    logic [7:0]  nz_src;
    logic        upd_nz;
    logic [3:0]  flags_nxt;

    // group decode from the top bits of the instruction word
    always_comb begin
        group_nxt = 3'd0;
        if (!instr_hi[15]) begin
            group_nxt = 3'd1;
        end else begin
            case (instr_hi[14:12])
                3'b000, 3'b001: group_nxt = 3'd2;
                3'b010, 3'b011: group_nxt = 3'd3;
                3'b100:         group_nxt = 3'd4;
                3'b101:         group_nxt = 3'd0;
                default:        group_nxt = 3'd5;
            endcase
        end
    end

    // register-pair form exists only for group 1 opcode 7
    assign pair_nxt = (group_nxt == 3'd1) && (instr_hi[14:12] == 3'd7);

    // shared 8-bit adder: subtraction is a + ~b + carry, so carry-out means "no borrow"
    assign is_sub  = (alu_oper == 4'd2) || (alu_oper == 4'd3) || (alu_oper == 4'd4);
    assign b_eff   = is_sub ? ~alu_b : alu_b;
    assign cin_eff = (alu_oper == 4'd0) ? 1'b0 :
                     ((alu_oper == 4'd1) || (alu_oper == 4'd3)) ? flags_in[FLAG_C] : 1'b1;
    assign sum9    = {1'b0, alu_a_lo} + {1'b0, b_eff} + {8'd0, cin_eff};
    assign v_arith = (alu_a_lo[7] == b_eff[7]) && (sum9[7] != alu_a_lo[7]);

    assign b_sext    = {{8{alu_b[7]}}, alu_b};
    assign pair_sum  = {alu_a_hi, alu_a_lo} + b_sext;
    assign pair_diff = {alu_a_hi, alu_a_lo} - b_sext;

    // ALU result and flag selection
    always_comb begin
        lo_nxt    = 8'h00;
        hi_nxt    = 8'h00;
        upd_nz    = 1'b1;
        flags_nxt = flags_in;
        case (alu_oper)
            4'd0, 4'd1, 4'd2, 4'd3: begin
                lo_nxt            = sum9[7:0];
                flags_nxt[FLAG_C] = sum9[8];
                flags_nxt[FLAG_V] = v_arith;
            end
            4'd4: begin
                lo_nxt            = alu_a_lo;
                flags_nxt[FLAG_C] = sum9[8];
                flags_nxt[FLAG_V] = v_arith;
            end
            4'd5: lo_nxt = alu_a_lo & alu_b;
            4'd6: lo_nxt = alu_a_lo | alu_b;
            4'd7: lo_nxt = alu_a_lo ^ alu_b;
            4'd8: begin
                lo_nxt            = {alu_a_lo[6:0], 1'b0};
                flags_nxt[FLAG_C] = alu_a_lo[7];
            end
            4'd9: begin
                lo_nxt            = {1'b0, alu_a_lo[7:1]};
                flags_nxt[FLAG_C] = alu_a_lo[0];
            end
            4'd10: begin
                lo_nxt            = {alu_a_lo[7], alu_a_lo[7:1]};
                flags_nxt[FLAG_C] = alu_a_lo[0];
            end
            4'd11: begin
                lo_nxt            = {alu_a_lo[6:0], flags_in[FLAG_C]};
                flags_nxt[FLAG_C] = alu_a_lo[7];
            end
            4'd12: begin
                lo_nxt            = {flags_in[FLAG_C], alu_a_lo[7:1]};
                flags_nxt[FLAG_C] = alu_a_lo[0];
            end
            4'd13: lo_nxt = alu_b;
            4'd14: begin
                {hi_nxt, lo_nxt} = pair_sum;
                upd_nz           = 1'b0;
            end
            default: begin
                {hi_nxt, lo_nxt} = pair_diff;
                upd_nz           = 1'b0;
            end
        endcase
        // compare reports N/Z of the difference even though it returns a_lo
        nz_src = (alu_oper == 4'd4) ? sum9[7:0] : lo_nxt;
        if (upd_nz) begin
            flags_nxt[FLAG_Z] = (nz_src == 8'h00);
            flags_nxt[FLAG_N] = nz_src[7];
        end
    end

    // output registers: capture on in_valid, hold otherwise; out_valid follows in_valid
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            group_out       <= 3'd0;
            instr_is_32_bit <= 1'b0;
            ig1_opcode      <= 3'd0;
            ig1_ra_index    <= 4'd0;
            ig1_imm8        <= 8'h00;
            ig1_ra_is_pair  <= 1'b0;
            alu_out_hi      <= 8'h00;
            alu_out_lo      <= 8'h00;
            flags_out       <= 4'h0;
            out_valid       <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                group_out       <= group_nxt;
                instr_is_32_bit <= (group_nxt == 3'd5);
                ig1_opcode      <= instr_hi[14:12];
                ig1_ra_index    <= instr_hi[11:8];
                ig1_imm8        <= instr_hi[7:0];
                ig1_ra_is_pair  <= pair_nxt;
                alu_out_hi      <= hi_nxt;
                alu_out_lo      <= lo_nxt;
                flags_out       <= flags_nxt;
            end
        end
    end

endmodule

// File: tb/tb_alu_decode_unit.sv
// Bench for alu_decode_unit: directed and random transactions, expected
// results queued at drive time and compared when the registered output appears.
module tb_alu_decode_unit;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic [15:0] instr_hi;
    logic [3:0]  alu_oper;
    logic [7:0]  alu_a_hi;
    logic [7:0]  alu_a_lo;
    logic [7:0]  alu_b;
    logic [3:0]  flags_in;
    logic [2:0]  group_out;
    logic        instr_is_32_bit;
    logic [2:0]  ig1_opcode;
    logic [3:0]  ig1_ra_index;
    logic [7:0]  ig1_imm8;
    logic        ig1_ra_is_pair;
    logic [7:0]  alu_out_hi;
    logic [7:0]  alu_out_lo;
    logic [3:0]  flags_out;
    logic        out_valid;

    typedef struct packed {
        logic [2:0] grp;
        logic       is32;
        logic [2:0] opc;
        logic [3:0] ra;
        logic [7:0] imm;
        logic       pair;
        logic [7:0] hi;
        logic [7:0] lo;
        logic [3:0] fl;
    } exp_t;

    exp_t sb_q[$];
    exp_t held;
    exp_t cur;
    int   n_chk  = 0;
    int   n_pass = 0;
    bit   mon_en = 0;

    alu_decode_unit dut (
        .clk             (clk),
        .reset           (reset),
        .in_valid        (in_valid),
        .instr_hi        (instr_hi),
        .alu_oper        (alu_oper),
        .alu_a_hi        (alu_a_hi),
        .alu_a_lo        (alu_a_lo),
        .alu_b           (alu_b),
        .flags_in        (flags_in),
        .group_out       (group_out),
        .instr_is_32_bit (instr_is_32_bit),
        .ig1_opcode      (ig1_opcode),
        .ig1_ra_index    (ig1_ra_index),
        .ig1_imm8        (ig1_imm8),
        .ig1_ra_is_pair  (ig1_ra_is_pair),
        .alu_out_hi      (alu_out_hi),
        .alu_out_lo      (alu_out_lo),
        .flags_out       (flags_out),
        .out_valid       (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_chk++;
        if (obs !== expv)
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, expv, $time);
        else
            n_pass++;
    endtask

    task automatic cmp_all(input string pfx, input exp_t e);
        chk({pfx, "group"},   32'(group_out),       32'(e.grp));
        chk({pfx, "is32"},    32'(instr_is_32_bit), 32'(e.is32));
        chk({pfx, "opcode"},  32'(ig1_opcode),      32'(e.opc));
        chk({pfx, "ra"},      32'(ig1_ra_index),    32'(e.ra));
        chk({pfx, "imm8"},    32'(ig1_imm8),        32'(e.imm));
        chk({pfx, "pair"},    32'(ig1_ra_is_pair),  32'(e.pair));
        chk({pfx, "out_hi"},  32'(alu_out_hi),      32'(e.hi));
        chk({pfx, "out_lo"},  32'(alu_out_lo),      32'(e.lo));
        chk({pfx, "flags"},   32'(flags_out),       32'(e.fl));
    endtask

    // reference model in plain integer arithmetic
    function automatic exp_t model(input logic [15:0] ins, input logic [3:0] op,
                                   input logic [7:0] ah, input logic [7:0] al,
                                   input logic [7:0] bv, input logic [3:0] fi);
        exp_t e;
        int a, b, c, r, sa, sb, sr, w;
        logic zf, cf, vf, nf;
        e = '0;
        if (ins[15] == 1'b0)              e.grp = 3'd1;
        else if (ins[15:13] == 3'b100)    e.grp = 3'd2;
        else if (ins[15:13] == 3'b101)    e.grp = 3'd3;
        else if (ins[15:12] == 4'b1100)   e.grp = 3'd4;
        else if (ins[15:12] == 4'b1101)   e.grp = 3'd0;
        else                              e.grp = 3'd5;
        e.is32 = (e.grp == 3'd5);
        e.opc  = ins[14:12];
        e.ra   = ins[11:8];
        e.imm  = ins[7:0];
        e.pair = (e.grp == 3'd1) && (ins[14:12] == 3'd7);
        a  = int'(al);
        b  = int'(bv);
        c  = int'(fi[1]);
        sa = al[7] ? a - 256 : a;
        sb = bv[7] ? b - 256 : b;
        zf = fi[0]; cf = fi[1]; vf = fi[2]; nf = fi[3];
        r  = 0;
        w  = 0;
        case (op)
            4'd0:  begin r = a + b;     cf = (r > 255); sr = sa + sb;     vf = (sr > 127 || sr < -128); end
            4'd1:  begin r = a + b + c; cf = (r > 255); sr = sa + sb + c; vf = (sr > 127 || sr < -128); end
            4'd2, 4'd4: begin r = a - b; cf = (r >= 0); sr = sa - sb; vf = (sr > 127 || sr < -128); end
            4'd3:  begin r = a - b - (1 - c); cf = (r >= 0); sr = sa - sb - (1 - c); vf = (sr > 127 || sr < -128); end
            4'd5:  r = a & b;
            4'd6:  r = a | b;
            4'd7:  r = a ^ b;
            4'd8:  begin r = a * 2;                          cf = (a >= 128); end
            4'd9:  begin r = a / 2;                          cf = (a % 2 == 1); end
            4'd10: begin r = a / 2 + ((a >= 128) ? 128 : 0); cf = (a % 2 == 1); end
            4'd11: begin r = a * 2 + c;                      cf = (a >= 128); end
            4'd12: begin r = a / 2 + c * 128;                cf = (a % 2 == 1); end
            4'd13: r = b;
            4'd14: w = int'(ah) * 256 + a + sb;
            default: w = int'(ah) * 256 + a - sb;
        endcase
        if (op < 4'd14) begin
            e.lo = (op == 4'd4) ? al : 8'(r);
            zf   = ((r & 255) == 0);
            nf   = ((r & 255) >= 128);
        end else begin
            e.hi = 8'(w >> 8);
            e.lo = 8'(w);
        end
        e.fl = {nf, vf, cf, zf};
        return e;
    endfunction

    task automatic send(input logic [15:0] ins, input logic [3:0] op, input logic [7:0] ah,
                        input logic [7:0] al, input logic [7:0] bv, input logic [3:0] fi);
        @(negedge clk);
        in_valid = 1'b1;
        instr_hi = ins;
        alu_oper = op;
        alu_a_hi = ah;
        alu_a_lo = al;
        alu_b    = bv;
        flags_in = fi;
        sb_q.push_back(model(ins, op, ah, al, bv, fi));
    endtask

    // idle cycles carry garbage on the data inputs so that hold behaviour is exercised
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
            instr_hi = 16'($urandom);
            alu_oper = 4'($urandom);
            alu_a_hi = 8'($urandom);
            alu_a_lo = 8'($urandom);
            alu_b    = 8'($urandom);
            flags_in = 4'($urandom);
        end
    endtask

    // output monitor: one cycle after each sampled in_valid a result must appear
    always @(posedge clk) begin
        #1;
        if (reset && mon_en) begin
            if (sb_q.size() != 0) begin
                cur = sb_q.pop_front();
                chk("out_valid", 32'(out_valid), 32'd1);
                cmp_all("res_", cur);
                held = cur;
            end else begin
                chk("out_valid_idle", 32'(out_valid), 32'd0);
                cmp_all("hold_", held);
            end
        end
    end

    initial begin
        reset    = 1'b0;
        in_valid = 1'b0;
        instr_hi = 16'h0;
        alu_oper = 4'h0;
        alu_a_hi = 8'h0;
        alu_a_lo = 8'h0;
        alu_b    = 8'h0;
        flags_in = 4'h0;
        held     = '0;

        #3;
        chk("rst_valid", 32'(out_valid), 32'd0);
        cmp_all("rst_", '0);
        @(negedge clk);
        @(negedge clk);
        reset  = 1'b1;
        mon_en = 1'b1;
        idle(1);

        // decode vectors
        send(16'h35A7, 4'd5, 8'h00, 8'h3C, 8'h0F, 4'h0);
        send(16'h7E10, 4'd6, 8'h00, 8'h00, 8'h00, 4'h0);
        send(16'hD000, 4'd13, 8'h00, 8'h00, 8'h80, 4'h0);
        send(16'hE000, 4'd7, 8'h00, 8'hAA, 8'hAA, 4'h6);
        send(16'h8123, 4'd8, 8'h00, 8'h81, 8'h00, 4'h4);
        send(16'hA456, 4'd9, 8'h00, 8'h01, 8'h00, 4'h0);
        send(16'hC789, 4'd10, 8'h00, 8'h81, 8'h00, 4'h0);
        send(16'hF000, 4'd11, 8'h00, 8'h80, 8'h00, 4'h2);
        idle(2);
        // arithmetic vectors
        send(16'h0000, 4'd0, 8'h00, 8'hFF, 8'h01, 4'h0);
        send(16'h0000, 4'd0, 8'h00, 8'h7F, 8'h01, 4'h0);
        send(16'h0000, 4'd2, 8'h00, 8'h05, 8'h07, 4'h0);
        send(16'h0000, 4'd3, 8'h00, 8'h05, 8'h05, 4'h0);
        send(16'h0000, 4'd1, 8'h00, 8'hFE, 8'h01, 4'h2);
        send(16'h0000, 4'd4, 8'h00, 8'h80, 8'h01, 4'h0);
        send(16'h0000, 4'd12, 8'h00, 8'h02, 8'h00, 4'h2);
        send(16'h0000, 4'd14, 8'h80, 8'hFE, 8'h04, 4'hA);
        send(16'h0000, 4'd15, 8'h80, 8'h00, 8'hFF, 4'h5);
        idle(1);

        // random traffic with gaps
        for (int i = 0; i < 120; i++) begin
            send(16'($urandom), 4'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 4'($urandom));
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
        end

        // reset asserted between edges with a result pending
        send(16'h35A7, 4'd0, 8'h12, 8'h7F, 8'h01, 4'hF);
        @(negedge clk);
        in_valid = 1'b1;
        instr_hi = 16'hE5A5;
        alu_oper = 4'd14;
        alu_a_hi = 8'h55;
        alu_a_lo = 8'h66;
        alu_b    = 8'h77;
        #2;
        reset = 1'b0;
        #1;
        chk("midrst_valid", 32'(out_valid), 32'd0);
        cmp_all("midrst_", '0);
        sb_q.delete();
        held = '0;
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        idle(3);
        send(16'h0ABC, 4'd13, 8'h00, 8'h00, 8'h5A, 4'h3);
        idle(2);

        chk("queue_drained", 32'(sb_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
